// File: rtl/regfile_win_ctrl.sv
// Load/sweep sequencer for a 128x32 register file with a 5-wide read port; win_valid/win_idx trail the issued read by 1 cycle.
// Input stalls via in_valid bubbles (in_ready high throughout LOAD); out_ready=0 holds the sweep with no read issued.
module regfile_win_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int WIN    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        load_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              win_valid,
  output logic [ADDR_W-1:0] win_idx,
  output logic              reg_enable,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic [ADDR_W-1:0] src_addr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [7:0]      WIN_L   = 8'(WIN);
  localparam logic [7:0]      DEPTH_L = 8'(DEPTH);
  localparam logic [ADDR_W:0] WIN_C   = (ADDR_W+1)'(WIN);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  logic [1:0]      state;
  logic [ADDR_W:0] len;
  logic [ADDR_W:0] wcnt;
  logic [ADDR_W:0] rcnt;

  logic len_ok;
  logic last_wr;
  logic last_rd;
  logic issue;

  assign len_ok  = (load_len >= WIN_L) && (load_len <= DEPTH_L);
  assign last_wr = (wcnt == len - ONE_C);
  assign last_rd = (rcnt == len - WIN_C);
  assign issue   = (state == S_READ) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      len       <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      win_valid <= 1'b0;
      win_idx   <= '0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      win_valid <= issue;
      if (issue) win_idx <= rcnt[ADDR_W-1:0];
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len_ok) begin
              len   <= (ADDR_W+1)'(load_len);
              wcnt  <= '0;
              state <= S_LOAD;
            end else begin
              // Rejected length: report immediately, never touch the register file.
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            wcnt <= wcnt + ONE_C;
            if (last_wr) begin
              rcnt  <= '0;
              state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (out_ready) begin
            rcnt <= rcnt + ONE_C;
            if (last_rd) begin
              // done lands with the final window in DRAIN.
              done  <= 1'b1;
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state != S_IDLE);
    in_ready   = (state == S_LOAD);
    reg_enable = 1'b0;
    reg_write  = 1'b0;
    write_addr = '0;
    src_addr   = '0;
    write_data = in_data;
    if (state == S_LOAD) begin
      reg_enable = in_valid;
      reg_write  = in_valid;
      write_addr = wcnt[ADDR_W-1:0];
    end else if (state == S_READ) begin
      reg_enable = out_ready;
      src_addr   = rcnt[ADDR_W-1:0];
    end
  end

endmodule

// File: tb/tb_regfile_win_ctrl.sv
// Directed bench for regfile_win_ctrl with a behavioural 128x32 register file on its outputs.
module tb_regfile_win_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  load_len;
  logic        busy, done, err;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_ready;
  logic        win_valid;
  logic [6:0]  win_idx;
  logic        reg_enable, reg_write;
  logic [6:0]  write_addr;
  logic [31:0] write_data;
  logic [6:0]  src_addr;

  logic [31:0] rf_mem [128];
  logic [31:0] rf_src [5];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_win_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .load_len(load_len),
    .busy(busy), .done(done), .err(err),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_ready(out_ready), .win_valid(win_valid), .win_idx(win_idx),
    .reg_enable(reg_enable), .reg_write(reg_write),
    .write_addr(write_addr), .write_data(write_data), .src_addr(src_addr)
  );

  // Register file: synchronous write, registered 5-wide read, outputs zeroed when disabled.
  always @(posedge clk) begin
    if (reg_enable && reg_write) begin
      rf_mem[write_addr] <= write_data;
    end else begin
      for (int k = 0; k < 5; k++)
        rf_src[k] <= reg_enable ? rf_mem[(int'(src_addr) + k) % 128] : 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] idle_outs();
    return {4'b0, busy, in_ready, win_valid, reg_enable, reg_write, done, err,
            write_addr, src_addr, win_idx};
  endfunction

  // vpat: 0 = in_valid always high, 1 = toggles 1,0,1,...
  // rpat: 0 = out_ready always high, 1 = low on every 2nd READ cycle.
  // abort_at: cycle (start cycle = 1) on which rst is pulsed; 0 = none.
  task automatic run(input int len, input int vpat, input int rpat,
                     input logic [31:0] base, input int exp_cyc, input int abort_at);
    int phase, nw, nr, cyc, lc, rc, nwin, prev_idx;
    bit prev_iss, fin;
    phase = 1; nw = 0; nr = 0; cyc = 1; lc = 0; rc = 0; nwin = 0;
    prev_idx = 0; prev_iss = 1'b0; fin = 1'b0;
    @(negedge clk);
    start = 1'b1; load_len = 8'(len); in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("start_busy", busy, 0);
    while (!fin) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == abort_at) begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("abort_outs", idle_outs(), 0);
        return;
      end
      in_valid  = (phase == 1) && (vpat == 0 || lc % 2 == 0);
      in_data   = base + 32'(nw);
      out_ready = (phase == 2) ? (rpat == 0 || rc % 2 == 0) : 1'b1;
      #1;
      chk("done", done, 32'(phase == 3));
      chk("win_valid", win_valid, 32'(prev_iss));
      if (win_valid && prev_iss) begin
        chk("win_idx", win_idx, prev_idx);
        for (int k = 0; k < 5; k++) chk("src", rf_src[k], base + 32'(prev_idx + k));
        nwin++;
      end
      prev_iss = 1'b0;
      case (phase)
        1: begin
          chk("in_ready", in_ready, 1);
          chk("ld_we", {reg_enable, reg_write}, {in_valid, in_valid});
          if (in_valid) begin
            chk("write_addr", write_addr, nw);
            nw++;
            if (nw == len) phase = 2;
          end
          lc++;
        end
        2: begin
          chk("rd_en", {in_ready, reg_write, reg_enable}, {2'b00, out_ready});
          if (out_ready) begin
            chk("src_addr", src_addr, nr);
            prev_iss = 1'b1;
            prev_idx = nr;
            nr++;
            if (nr == len - 4) phase = 3;
          end
          rc++;
        end
        default: begin
          chk("drain_en", {in_ready, reg_enable, err, busy}, 4'b0001);
          chk("cycles", cyc, exp_cyc);
          chk("windows", nwin, len - 4);
          chk("writes", nw, len);
          fin = 1'b1;
        end
      endcase
      if (cyc > 600) begin
        chk("timeout", cyc, 0);
        fin = 1'b1;
      end
    end
    @(negedge clk);
    #1 chk("idle_after", {busy, done, in_ready, reg_enable}, 0);
  endtask

  task automatic bad_len(input int len);
    @(negedge clk);
    start = 1'b1; load_len = 8'(len); in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("bad_start", {busy, done, err, in_ready, reg_enable}, 0);
    @(negedge clk);
    start = 1'b0;
    #1 chk("bad_pulse", {busy, done, err, in_ready, reg_enable}, 5'b01100);
    @(negedge clk);
    #1 chk("bad_after", {busy, done, err, in_ready, reg_enable}, 0);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load_len = 8'd0; in_valid = 1'b0;
    in_data = 32'h0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("reset_outs", idle_outs(), 0);
    rst = 1'b0;

    run(8,   0, 0, 32'h10,   14,  0);
    run(6,   1, 0, 32'h100,  15,  0);
    run(10,  0, 1, 32'h200,  23,  0);
    bad_len(4);
    bad_len(0);
    bad_len(129);
    run(128, 0, 0, 32'h1000, 254, 0);
    run(8,   0, 0, 32'h300,  14,  5);
    run(8,   0, 0, 32'h400,  14,  11);
    run(8,   0, 0, 32'h500,  14,  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
